// File: rtl/id_ex_pkg.sv
// Shared defaults and FSM encoding for the ID/EX pipeline register slice.
package id_ex_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_REG_ADDR_W = 5;
  localparam int unsigned DEF_CTRL_W     = 16;
  localparam int unsigned STALL_CNT_W    = 16;

  // Stage FSM encoding, kept as plain constants for compatibility with
  // existing code that compares against the raw state bits.
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN   = 1'b0;
  localparam state_t ST_STALL = 1'b1;

endpackage

// File: rtl/operand_bypass.sv
// Register operand select: r0 reads as zero, otherwise a same-cycle
// write-back to the same register overrides the register-file read.
module operand_bypass
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  wb_we,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     operand
);

  // r0 check comes first so a write-back aimed at r0 can never leak through.
  always_comb begin
    operand = rf_data;
    if (src_addr == '0) begin
      operand = '0;
    end else if (wb_we && (wb_addr == src_addr)) begin
      operand = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass, load-use stall detection,
// flush handling and a saturating stall-cycle counter.
module id_ex_stage
  import id_ex_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int unsigned CTRL_W     = DEF_CTRL_W
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic                   InValid,
  input  logic [REG_ADDR_W-1:0]  RsAddr,
  input  logic [REG_ADDR_W-1:0]  RtAddr,
  input  logic [REG_ADDR_W-1:0]  RdAddr,
  input  logic [DATA_W-1:0]      ReadData1,
  input  logic [DATA_W-1:0]      ReadData2,
  input  logic [DATA_W-1:0]      Imm,
  input  logic [DATA_W-1:0]      PCPlus4,
  input  logic [CTRL_W-1:0]      Ctrl,
  input  logic                   MemRead,
  input  logic                   RegWrite,
  input  logic                   WBRegWrite,
  input  logic [REG_ADDR_W-1:0]  WBWriteRegister,
  input  logic [DATA_W-1:0]      WBWriteData,
  input  logic                   Flush,
  output logic                   StallID,
  output logic                   ExValid,
  output logic                   ExMemRead,
  output logic                   ExRegWrite,
  output logic [CTRL_W-1:0]      ExCtrl,
  output logic [REG_ADDR_W-1:0]  ExRsAddr,
  output logic [REG_ADDR_W-1:0]  ExRtAddr,
  output logic [REG_ADDR_W-1:0]  ExRd,
  output logic [DATA_W-1:0]      ExA,
  output logic [DATA_W-1:0]      ExB,
  output logic [DATA_W-1:0]      ExImm,
  output logic [DATA_W-1:0]      ExPCPlus4,
  output logic [STALL_CNT_W-1:0] StallCount
);

  logic [DATA_W-1:0]      op_a;
  logic [DATA_W-1:0]      op_b;
  logic                   hazard;
  logic                   load;
  state_t                 state;
  logic [STALL_CNT_W-1:0] stall_cnt;

  operand_bypass #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_bypass_a (
    .src_addr (RsAddr),
    .rf_data  (ReadData1),
    .wb_we    (WBRegWrite),
    .wb_addr  (WBWriteRegister),
    .wb_data  (WBWriteData),
    .operand  (op_a)
  );

  operand_bypass #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_bypass_b (
    .src_addr (RtAddr),
    .rf_data  (ReadData2),
    .wb_we    (WBRegWrite),
    .wb_addr  (WBWriteRegister),
    .wb_data  (WBWriteData),
    .operand  (op_b)
  );

  // Load-use detection against the instruction currently in EX. The state
  // term is redundant with ExValid (STALL always follows a bubble) but makes
  // the one-cycle stall guarantee explicit.
  always_comb begin
    hazard = (state == ST_RUN) && ExValid && ExMemRead && ExRegWrite &&
             (ExRd != '0) && InValid &&
             ((ExRd == RsAddr) || (ExRd == RtAddr));
    StallID = hazard && !Flush;
    load    = InValid && !Flush && !StallID;
  end

  // EX payload: load the decode slot on a normal edge, otherwise insert a
  // fully zeroed bubble.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ExValid    <= 1'b0;
      ExMemRead  <= 1'b0;
      ExRegWrite <= 1'b0;
      ExCtrl     <= '0;
      ExRsAddr   <= '0;
      ExRtAddr   <= '0;
      ExRd       <= '0;
      ExA        <= '0;
      ExB        <= '0;
      ExImm      <= '0;
      ExPCPlus4  <= '0;
    end else if (load) begin
      ExValid    <= 1'b1;
      ExMemRead  <= MemRead;
      ExRegWrite <= RegWrite;
      ExCtrl     <= Ctrl;
      ExRsAddr   <= RsAddr;
      ExRtAddr   <= RtAddr;
      ExRd       <= RdAddr;
      ExA        <= op_a;
      ExB        <= op_b;
      ExImm      <= Imm;
      ExPCPlus4  <= PCPlus4;
    end else begin
      ExValid    <= 1'b0;
      ExMemRead  <= 1'b0;
      ExRegWrite <= 1'b0;
      ExCtrl     <= '0;
      ExRsAddr   <= '0;
      ExRtAddr   <= '0;
      ExRd       <= '0;
      ExA        <= '0;
      ExB        <= '0;
      ExImm      <= '0;
      ExPCPlus4  <= '0;
    end
  end

  // RUN/STALL tracking: a stall edge enters STALL, which always exits next edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= ST_RUN;
    end else if ((state == ST_RUN) && StallID) begin
      state <= ST_STALL;
    end else begin
      state <= ST_RUN;
    end
  end

  // Saturating count of stall edges.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (StallID && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign StallCount = stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        InValid = 1'b0;
  logic [4:0]  RsAddr = '0, RtAddr = '0, RdAddr = '0;
  logic [31:0] ReadData1 = '0, ReadData2 = '0, Imm = '0, PCPlus4 = '0;
  logic [15:0] Ctrl = '0;
  logic        MemRead = 1'b0, RegWrite = 1'b0;
  logic        WBRegWrite = 1'b0;
  logic [4:0]  WBWriteRegister = '0;
  logic [31:0] WBWriteData = '0;
  logic        Flush = 1'b0;
  logic        StallID;
  logic        ExValid, ExMemRead, ExRegWrite;
  logic [15:0] ExCtrl;
  logic [4:0]  ExRsAddr, ExRtAddr, ExRd;
  logic [31:0] ExA, ExB, ExImm, ExPCPlus4;
  logic [15:0] StallCount;

  id_ex_stage #(
    .DATA_W     (32),
    .REG_ADDR_W (5),
    .CTRL_W     (16)
  ) dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .InValid         (InValid),
    .RsAddr          (RsAddr),
    .RtAddr          (RtAddr),
    .RdAddr          (RdAddr),
    .ReadData1       (ReadData1),
    .ReadData2       (ReadData2),
    .Imm             (Imm),
    .PCPlus4         (PCPlus4),
    .Ctrl            (Ctrl),
    .MemRead         (MemRead),
    .RegWrite        (RegWrite),
    .WBRegWrite      (WBRegWrite),
    .WBWriteRegister (WBWriteRegister),
    .WBWriteData     (WBWriteData),
    .Flush           (Flush),
    .StallID         (StallID),
    .ExValid         (ExValid),
    .ExMemRead       (ExMemRead),
    .ExRegWrite      (ExRegWrite),
    .ExCtrl          (ExCtrl),
    .ExRsAddr        (ExRsAddr),
    .ExRtAddr        (ExRtAddr),
    .ExRd            (ExRd),
    .ExA             (ExA),
    .ExB             (ExB),
    .ExImm           (ExImm),
    .ExPCPlus4       (ExPCPlus4),
    .StallCount      (StallCount)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  // Reference view of what sits in EX after each edge.
  typedef struct {
    bit        valid;
    bit        memread;
    bit        regwrite;
    bit [15:0] ctrl;
    bit [4:0]  rs, rt, rd;
    bit [31:0] a, b, imm, pc;
  } ex_t;

  ex_t         m;
  int unsigned m_cnt;
  bit          held;
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] ref_operand(input bit [4:0] src, input bit [31:0] rf,
                                            input bit we, input bit [4:0] wa, input bit [31:0] wd);
    if (src == 0) return 0;
    if (we && wa == src) return wd;
    return rf;
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    m_cnt = 0;
    held = 0;
  endtask

  task automatic compare_all();
    check("ex_valid",    32'(ExValid),    32'(m.valid));
    check("ex_memread",  32'(ExMemRead),  32'(m.memread));
    check("ex_regwrite", 32'(ExRegWrite), 32'(m.regwrite));
    check("ex_ctrl",     32'(ExCtrl),     32'(m.ctrl));
    check("ex_rs",       32'(ExRsAddr),   32'(m.rs));
    check("ex_rt",       32'(ExRtAddr),   32'(m.rt));
    check("ex_rd",       32'(ExRd),       32'(m.rd));
    check("ex_a",        ExA,             m.a);
    check("ex_b",        ExB,             m.b);
    check("ex_imm",      ExImm,           m.imm);
    check("ex_pc4",      ExPCPlus4,       m.pc);
    check("stall_count", 32'(StallCount), m_cnt);
  endtask

  // Called just after a falling edge with the decode slot driven: checks the
  // combinational stall, advances one rising edge, checks EX, returns at the
  // next falling edge.
  task automatic step();
    bit  exp_stall;
    ex_t nx;
    #1;
    exp_stall = m.valid && m.memread && m.regwrite && (m.rd != 0) && InValid &&
                ((m.rd == RsAddr) || (m.rd == RtAddr)) && !Flush;
    check("stall_id", 32'(StallID), 32'(exp_stall));
    nx = '{default: '0};
    if (InValid && !Flush && !exp_stall) begin
      nx.valid    = 1;
      nx.memread  = MemRead;
      nx.regwrite = RegWrite;
      nx.ctrl     = Ctrl;
      nx.rs       = RsAddr;
      nx.rt       = RtAddr;
      nx.rd       = RdAddr;
      nx.a        = ref_operand(RsAddr, ReadData1, WBRegWrite, WBWriteRegister, WBWriteData);
      nx.b        = ref_operand(RtAddr, ReadData2, WBRegWrite, WBWriteRegister, WBWriteData);
      nx.imm      = Imm;
      nx.pc       = PCPlus4;
    end
    held = exp_stall;
    @(posedge Clk);
    #1;
    m = nx;
    if (exp_stall && m_cnt < 65535) m_cnt++;
    compare_all();
    @(negedge Clk);
  endtask

  task automatic plain_slot(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
    InValid = 1; RsAddr = rs; RtAddr = rt; RdAddr = rd;
    ReadData1 = $urandom; ReadData2 = $urandom; Imm = $urandom; PCPlus4 = $urandom;
    Ctrl = 16'($urandom); MemRead = 0; RegWrite = 1;
    WBRegWrite = 0; WBWriteRegister = 0; WBWriteData = 0; Flush = 0;
  endtask

  // lw r8 enters EX, then a consumer of r8 sits in decode.
  task automatic load_use(input bit flush_it);
    plain_slot(5'd1, 5'd2, 5'd8);
    MemRead = 1;
    step();
    plain_slot(5'd8, 5'd3, 5'd4);
    ReadData1 = 32'h1111;
    Flush = flush_it;
    step();
  endtask

  task automatic rand_decode();
    InValid   = ($urandom_range(0, 9) != 0);
    RsAddr    = 5'($urandom_range(0, 7));
    RtAddr    = 5'($urandom_range(0, 7));
    RdAddr    = 5'($urandom_range(0, 7));
    ReadData1 = $urandom;
    ReadData2 = $urandom;
    Imm       = $urandom;
    PCPlus4   = $urandom;
    Ctrl      = 16'($urandom);
    MemRead   = ($urandom_range(0, 1) == 1);
    RegWrite  = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int unsigned cnt_before;
    model_reset();

    // Reset state while clock runs and inputs carry a live instruction.
    plain_slot(5'd3, 5'd4, 5'd5);
    repeat (3) @(posedge Clk);
    #1;
    compare_all();
    check("stall_in_reset", 32'(StallID), 32'h0);
    @(negedge Clk);
    Rst_n = 1;

    // Pass-through on the first edge after reset.
    plain_slot(5'd9, 5'd10, 5'd11);
    ReadData1 = 32'd7; ReadData2 = 32'd9; Imm = 32'h14;
    step();
    check("pass_a", ExA, 32'd7);
    check("pass_b", ExB, 32'd9);
    check("pass_imm", ExImm, 32'h14);
    check("pass_valid", 32'(ExValid), 32'h1);

    // Write-back bypass, then write-back to r0 ignored.
    plain_slot(5'd21, 5'd2, 5'd3);
    ReadData1 = 32'd1; WBRegWrite = 1; WBWriteRegister = 5'd21; WBWriteData = 32'h14;
    step();
    check("wb_bypass_a", ExA, 32'h14);
    plain_slot(5'd0, 5'd2, 5'd3);
    ReadData1 = 32'h99; WBRegWrite = 1; WBWriteRegister = 5'd0; WBWriteData = 32'h55;
    step();
    check("wb_r0_a", ExA, 32'h0);

    // InValid low produces a bubble.
    plain_slot(5'd5, 5'd6, 5'd7);
    InValid = 0;
    step();
    check("invalid_bubble", ExA, 32'h0);

    // Load-use: one stall cycle then issue with the load result bypassed.
    cnt_before = m_cnt;
    load_use(0);
    check("lu_valid", 32'(ExValid), 32'h0);
    check("lu_count", 32'(StallCount), cnt_before + 1);
    WBRegWrite = 1; WBWriteRegister = 5'd8; WBWriteData = 32'hABCD;
    step();
    check("lu_issue_valid", 32'(ExValid), 32'h1);
    check("lu_issue_a", ExA, 32'hABCD);

    // Flush wins over the hazard.
    cnt_before = m_cnt;
    load_use(1);
    check("flush_valid", 32'(ExValid), 32'h0);
    check("flush_count", 32'(StallCount), cnt_before);

    // Asynchronous reset asserted between edges while in STALL.
    load_use(0);
    #2;
    Rst_n = 0;
    #1;
    model_reset();
    compare_all();
    check("stall_id_rst", 32'(StallID), 32'h0);
    @(negedge Clk);
    Rst_n = 1;
    plain_slot(5'd8, 5'd3, 5'd4);
    step();
    check("post_rst_valid", 32'(ExValid), 32'h1);

    // Saturation: preload the counter near the top, then stall repeatedly.
    force dut.stall_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt;
    m_cnt = 32'hFFFE;
    load_use(0);
    check("sat_reach", 32'(StallCount), 32'hFFFF);
    load_use(0);
    load_use(0);
    check("sat_hold", 32'(StallCount), 32'hFFFF);

    // Randomized traffic; a stalled decode slot is held as IF/ID would hold it.
    held = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!held) rand_decode();
      WBRegWrite      = ($urandom_range(0, 1) == 1);
      WBWriteRegister = 5'($urandom_range(0, 7));
      WBWriteData     = $urandom;
      Flush           = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/immediate/PC width.
REQ-002 Parameter REG_ADDR_W, 5, register address width.
REQ-003 Parameter CTRL_W, 16, opaque EX/MEM/WB control bundle width.
REQ-004 Clk  in  1  single clock; all state updates on rising edge.
REQ-005 Rst_n  in  1  reset, asynchronous, active-low.
REQ-006 InValid  in  1  decode slot holds a real instruction.
REQ-007 RsAddr, RtAddr, RdAddr  in  REG_ADDR_W  source/destination register numbers.
REQ-008 ReadData1, ReadData2  in  DATA_W  register-file read data for RsAddr/RtAddr.
REQ-009 Imm, PCPlus4  in  DATA_W  sign-extended immediate, next PC.
REQ-010 Ctrl  in  CTRL_W; MemRead, RegWrite  in  1  decoded controls.
REQ-011 WBRegWrite  in  1; WBWriteRegister  in  REG_ADDR_W; WBWriteData  in  DATA_W  same-cycle write-back port.
REQ-012 Flush  in  1  branch/jump redirect; kill decode slot.
REQ-013 StallID  out  1  hold PC and IF/ID this cycle.
REQ-014 ExValid, ExMemRead, ExRegWrite  out  1; ExCtrl  out  CTRL_W.
REQ-015 ExRsAddr, ExRtAddr, ExRd  out  REG_ADDR_W; ExA, ExB, ExImm, ExPCPlus4  out  DATA_W.
REQ-016 StallCount  out  16  saturating count of stall cycles.

Function
REQ-017 Operand A SHALL be 0 if RsAddr==0; else WBWriteData if WBRegWrite && WBWriteRegister==RsAddr; else ReadData1.
REQ-018 Operand B SHALL follow REQ-017 using RtAddr/ReadData2.
REQ-019 Hazard SHALL be ExValid && ExMemRead && ExRegWrite && ExRd!=0 && InValid && (ExRd==RsAddr || (ExRd==RtAddr)).
REQ-020 StallID SHALL equal Hazard && !Flush, combinational, same cycle.
REQ-021 Normal edge (no Flush, no stall): all Ex* outputs SHALL load the decode-slot values, ExValid=InValid; latency exactly one cycle.
REQ-022 Bubble edge (Flush, stall, or InValid=0): ExValid, ExMemRead, ExRegWrite, ExCtrl SHALL be 0; ExA/ExB/ExImm/ExPCPlus4/address outputs SHALL be 0.
REQ-023 Flush SHALL take priority over Hazard; no stall cycle counted.
REQ-024 FSM states RUN, STALL: RUN->STALL on stall edge; STALL->RUN unconditionally next edge; RUN->RUN otherwise.
REQ-025 In STALL, ExValid is 0 so Hazard SHALL be 0; a load-use stall lasts exactly one cycle.
REQ-026 StallCount SHALL increment on each stall edge, saturating at 16'hFFFF.
REQ-027 Write-back bypass to register 0 SHALL be ignored (operand stays 0).

Reset
REQ-028 Rst_n low SHALL immediately clear all Ex* outputs, StallCount, and FSM to RUN, independent of Clk.
REQ-029 StallID SHALL be 0 while Rst_n low; reset mid-stall SHALL return to RUN, no pending bubble.
REQ-030 First rising edge after Rst_n deasserts SHALL behave as a normal RUN edge.

Structure
REQ-031 Package id_ex_pkg SHALL hold DATA_W, REG_ADDR_W, CTRL_W defaults and the RUN/STALL state encoding.
REQ-032 Sub-module operand_bypass SHALL implement REQ-017 and be instantiated twice (A, B).

Verification
REQ-033 Pass-through: InValid=1, Rs=9, Rt=10, ReadData1=7, ReadData2=9, Imm=0x14 -> next edge ExA=7, ExB=9, ExImm=0x14, ExValid=1.
REQ-034 WB bypass: Rs=21, ReadData1=1, WBRegWrite=1, WBWriteRegister=21, WBWriteData=0x14 -> ExA=0x14; same with WBWriteRegister=0, Rs=0 -> ExA=0.
REQ-035 Load-use: Ex holds lw (MemRead=1, RegWrite=1, Rd=8); decode Rs=8 -> StallID=1 one cycle, bubble (ExValid=0), StallCount=1, then instruction issues with ExA from bypass.
REQ-036 Flush vs stall: same as REQ-035 plus Flush=1 -> StallID=0, ExValid=0, StallCount unchanged.
REQ-037 Async reset: Rst_n low mid-clock during STALL -> all outputs 0 before next edge; StallCount saturation: force 0xFFFF stalls -> holds 0xFFFF.
